// File: rtl/benes_route_sequencer.sv
// Holds precomputed Benes switch settings for both interconnect networks and
// sequences each route through fill, data-valid hold and drain phases.
module benes_route_sequencer #(
  parameter int SIZE        = 8,
  parameter int SWITCH_NUM  = SIZE / 2,
  parameter int STAGE_NUM   = 2 * $clog2(SIZE) - 1,
  parameter int NET_LATENCY = STAGE_NUM,
  parameter int CFG_DEPTH   = 16,
  parameter int HOLD_W      = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_we,
  input  logic                              cfg_net,
  input  logic [$clog2(CFG_DEPTH)-1:0]      cfg_addr,
  input  logic [STAGE_NUM*SWITCH_NUM-1:0]   cfg_wdata,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [$clog2(CFG_DEPTH)-1:0]      req_slot_idx,
  input  logic [$clog2(CFG_DEPTH)-1:0]      req_mod_idx,
  input  logic [HOLD_W-1:0]                 req_hold,
  output logic [SWITCH_NUM-1:0]             slot_select   [0:STAGE_NUM-1],
  output logic [SWITCH_NUM-1:0]             module_select [0:STAGE_NUM-1],
  output logic                              route_active,
  output logic                              out_valid,
  output logic                              done
);

  localparam int TW    = STAGE_NUM * SWITCH_NUM;
  localparam int LAT_W = $clog2(NET_LATENCY + 1);
  localparam int CNT_W = (HOLD_W > LAT_W) ? HOLD_W : LAT_W;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(NET_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, FILL, HOLD, DRAIN} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [HOLD_W-1:0]  hold_reg;
  logic [CNT_W-1:0]   hold_last;
  logic               accept;
  logic               out_valid_reg, out_valid_next;
  logic               route_active_reg, route_active_next;
  logic               done_reg, done_next;
  logic [TW-1:0]      slot_sel_reg, mod_sel_reg;
  logic [TW-1:0]      slot_tab [CFG_DEPTH];
  logic [TW-1:0]      mod_tab  [CFG_DEPTH];

  // A zero hold length still yields one data-valid cycle.
  assign hold_last = (hold_reg == '0) ? '0 : CNT_W'(hold_reg) - CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CFG_DEPTH; i++) begin
        slot_tab[i] <= '0;
        mod_tab[i]  <= '0;
      end
    end else if (cfg_we) begin
      if (cfg_net) mod_tab[cfg_addr]  <= cfg_wdata;
      else         slot_tab[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      hold_reg         <= '0;
      out_valid_reg    <= 1'b0;
      route_active_reg <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      out_valid_reg    <= out_valid_next;
      route_active_reg <= route_active_next;
      done_reg         <= done_next;
      if (accept) hold_reg <= req_hold;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = FILL;
          cnt_next   = LAT_LAST;
        end
      end
      FILL: begin
        if (cnt_reg == '0) begin
          state_next = HOLD;
          cnt_next   = hold_last;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_reg == '0) begin
          state_next = DRAIN;
          cnt_next   = LAT_LAST;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    out_valid_next    = (state_next == HOLD);
    route_active_next = (state_next != IDLE);
    done_next         = (state_reg == DRAIN) && (state_next == IDLE);
  end

  // Table reads see pre-write contents, so a same-edge config write is not picked up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_sel_reg <= '0;
      mod_sel_reg  <= '0;
    end else if (accept) begin
      slot_sel_reg <= slot_tab[req_slot_idx];
      mod_sel_reg  <= mod_tab[req_mod_idx];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGE_NUM; gi++) begin : g_stage
      assign slot_select[gi]   = slot_sel_reg[gi*SWITCH_NUM +: SWITCH_NUM];
      assign module_select[gi] = mod_sel_reg[gi*SWITCH_NUM +: SWITCH_NUM];
    end
  endgenerate

  assign req_ready    = (state_reg == IDLE);
  assign out_valid    = out_valid_reg;
  assign route_active = route_active_reg;
  assign done         = done_reg;

endmodule
